spi_responder: RTL and testbench

- Chip-side SPI slave (responder): the counterpart of the board's SPI readout master (csb/sck/mosi out, miso in).
- Used in simulation benches and in loopback firmware builds to emulate the AstroPix SPI port.
- Oversamples the SPI pins in the system clock domain, deserialises MOSI into bytes, and serialises bytes from a transmit stream onto MISO.
- SPI mode 0 only, MSB first, byte-oriented.

---
 rtl/spi_responder.sv | 169 ++++++++++++++++
 tb/tb_spi_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples csb/sck/mosi in the system clock domain,
// deserialises MOSI into bytes and serialises a transmit byte stream onto MISO.
module spi_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'h00,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 spi_csb,
   input  logic                 spi_clock,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   input  logic [7:0]           tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   output logic                 tx_underflow,
   output logic                 frame_active,
   output logic                 frame_done,
   output logic [CNT_WIDTH-1:0] frame_bytes,
   output logic                 frame_abort
);

   localparam int unsigned BIT_CNT_W = 3;

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] csb_sync_q, sck_sync_q, mosi_sync_q;
   logic                   csb_hist_q, sck_hist_q;
   logic [7:0]             tx_shift_q, rx_shift_q, rx_data_q;
   logic [BIT_CNT_W-1:0]   bit_cnt_q;
   logic [CNT_WIDTH-1:0]   byte_cnt_q, frame_bytes_q;
   logic                   byte_boundary_q;
   logic                   spi_miso_q, tx_ready_q, rx_valid_q, tx_underflow_q;
   logic                   frame_active_q, frame_done_q, frame_abort_q;

   logic                   csb_s, sck_s, mosi_s;
   logic                   csb_rise, csb_fall, sck_rise, sck_fall;
   logic [7:0]             load_byte_d, rx_shift_d;
   logic [CNT_WIDTH-1:0]   byte_cnt_d;
   logic                   last_bit;

   assign csb_s  = csb_sync_q[SYNC_STAGES-1];
   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign csb_rise = ~csb_hist_q & csb_s;
   assign csb_fall = csb_hist_q & ~csb_s;
   assign sck_rise = ~sck_hist_q & sck_s;
   assign sck_fall = sck_hist_q & ~sck_s;

   assign load_byte_d = tx_valid ? tx_data : IDLE_BYTE;
   assign rx_shift_d  = {rx_shift_q[6:0], mosi_s};
   assign byte_cnt_d  = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + CNT_WIDTH'(1);
   assign last_bit    = (bit_cnt_q == BIT_CNT_W'(7));

   // Pin synchronisers plus one history flop each for edge detection
   always_ff @(posedge clock) begin
      if (reset) begin
         csb_sync_q  <= '0;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         csb_hist_q  <= 1'b0;
         sck_hist_q  <= 1'b0;
      end else begin
         csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clock};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         csb_hist_q  <= csb_s;
         sck_hist_q  <= sck_s;
      end
   end

   // Frame FSM with shift registers; strobes default low every cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= WAIT_IDLE;
         tx_shift_q      <= '0;
         rx_shift_q      <= '0;
         rx_data_q       <= '0;
         bit_cnt_q       <= '0;
         byte_cnt_q      <= '0;
         frame_bytes_q   <= '0;
         byte_boundary_q <= 1'b0;
         spi_miso_q      <= 1'b0;
         tx_ready_q      <= 1'b0;
         rx_valid_q      <= 1'b0;
         tx_underflow_q  <= 1'b0;
         frame_active_q  <= 1'b0;
         frame_done_q    <= 1'b0;
         frame_abort_q   <= 1'b0;
      end else begin
         tx_ready_q     <= 1'b0;
         rx_valid_q     <= 1'b0;
         tx_underflow_q <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_abort_q  <= 1'b0;
         unique case (state_q)
            WAIT_IDLE: begin
               spi_miso_q <= 1'b0;
               if (csb_s) state_q <= IDLE;
            end
            IDLE: begin
               spi_miso_q <= 1'b0;
               if (csb_fall) begin
                  tx_shift_q      <= load_byte_d;
                  spi_miso_q      <= load_byte_d[7];
                  tx_ready_q      <= tx_valid;
                  tx_underflow_q  <= ~tx_valid;
                  bit_cnt_q       <= '0;
                  byte_cnt_q      <= '0;
                  byte_boundary_q <= 1'b0;
                  frame_active_q  <= 1'b1;
                  state_q         <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (csb_rise) begin
                  // A simultaneous 8th rising edge is dropped, not reported as abort
                  frame_done_q    <= 1'b1;
                  frame_bytes_q   <= byte_cnt_q;
                  frame_abort_q   <= (bit_cnt_q != '0) && !(sck_rise && last_bit);
                  frame_active_q  <= 1'b0;
                  spi_miso_q      <= 1'b0;
                  byte_boundary_q <= 1'b0;
                  state_q         <= IDLE;
               end else if (sck_rise) begin
                  rx_shift_q <= rx_shift_d;
                  if (last_bit) begin
                     rx_data_q       <= rx_shift_d;
                     rx_valid_q      <= 1'b1;
                     byte_cnt_q      <= byte_cnt_d;
                     bit_cnt_q       <= '0;
                     byte_boundary_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  end
               end else if (sck_fall) begin
                  if (byte_boundary_q) begin
                     tx_shift_q      <= load_byte_d;
                     spi_miso_q      <= load_byte_d[7];
                     tx_ready_q      <= tx_valid;
                     tx_underflow_q  <= ~tx_valid;
                     byte_boundary_q <= 1'b0;
                  end else begin
                     tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                     spi_miso_q <= tx_shift_q[6];
                  end
               end
            end
            default: state_q <= WAIT_IDLE;
         endcase
      end
   end

   assign spi_miso     = spi_miso_q;
   assign tx_ready     = tx_ready_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign tx_underflow = tx_underflow_q;
   assign frame_active = frame_active_q;
   assign frame_done   = frame_done_q;
   assign frame_bytes  = frame_bytes_q;
   assign frame_abort  = frame_abort_q;

endmodule

// File: tb/tb_spi_responder.sv
// Scoreboard bench for spi_responder: a mode-0 master model drives frames while
// expected RX bytes and MISO bits are queued and checked as the DUT produces them.
module tb_spi_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        spi_csb, spi_clock, spi_mosi, spi_miso;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, tx_underflow, frame_active, frame_done, frame_abort;
   logic [15:0] frame_bytes;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   int          n_pop = 0, n_unf = 0, n_done = 0;
   int          last_bytes = 0, last_abort = 0;
   logic [7:0]  tx_q[$];
   logic [7:0]  exp_rx[$];
   logic        exp_miso[$];

   spi_responder dut (
      .clock       (clock),
      .reset       (reset),
      .spi_csb     (spi_csb),
      .spi_clock   (spi_clock),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_underflow(tx_underflow),
      .frame_active(frame_active),
      .frame_done  (frame_done),
      .frame_bytes (frame_bytes),
      .frame_abort (frame_abort)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: tx stream source, strobe counters, rx scoreboard
   always @(negedge clock) begin
      logic [7:0] exp_b;
      if (tx_ready) begin
         n_pop++;
         if (tx_q.size() != 0) exp_b = tx_q.pop_front();
      end
      if (tx_underflow) n_unf++;
      if (frame_done) begin
         n_done++;
         last_bytes = int'(frame_bytes);
         last_abort = int'(frame_abort);
      end
      if (frame_abort && !frame_done) check_eq("abort_without_done", 32'(frame_abort), 32'd0);
      if (rx_valid) begin
         if (exp_rx.size() == 0) check_eq("rx_spurious", 32'(rx_valid), 32'd0);
         else begin
            exp_b = exp_rx.pop_front();
            check_eq("rx_byte", 32'(rx_data), 32'(exp_b));
         end
      end
      tx_valid = (tx_q.size() != 0);
      tx_data  = tx_valid ? tx_q[0] : 8'h00;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic push_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) exp_miso.push_back(b[7-i]);
   endtask

   task automatic sck_bits(input int n, input int half);
      for (int i = 0; i < n; i++) begin
         spi_mosi = i[0];
         wait_cyc(half);
         spi_clock = 1'b1;
         wait_cyc(half);
         spi_clock = 1'b0;
      end
   endtask

   // Full frame; csb rises together with the last SCK falling edge
   task automatic frame(input int nbits, input logic [31:0] word, input int half, input bit chk);
      logic b;
      spi_csb = 1'b0;
      wait_cyc(8);
      check_eq("frame_active", 32'(frame_active), 32'd1);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = word[nbits-1-i];
         wait_cyc(half);
         if (chk) begin
            if (exp_miso.size() == 0) check_eq("miso_underrun", 32'(exp_miso.size()), 32'd1);
            else begin
               b = exp_miso.pop_front();
               check_eq($sformatf("miso_bit%0d", i), 32'(spi_miso), 32'(b));
            end
         end
         spi_clock = 1'b1;
         wait_cyc(half);
         spi_clock = 1'b0;
         if (i == nbits - 1) spi_csb = 1'b1;
      end
      spi_mosi = 1'b0;
      wait_cyc(10);
   endtask

   task automatic expect_frame(input string tag, input int d0, input int p0, input int u0,
                               input int bytes, input int abort, input int pops, input int unf);
      check_eq({tag, "_done"},  32'(n_done - d0), 32'd1);
      check_eq({tag, "_bytes"}, 32'(last_bytes),  32'(bytes));
      check_eq({tag, "_abort"}, 32'(last_abort),  32'(abort));
      check_eq({tag, "_pops"},  32'(n_pop - p0),  32'(pops));
      check_eq({tag, "_unf"},   32'(n_unf - u0),  32'(unf));
      check_eq({tag, "_idle"},  32'(frame_active), 32'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      @(negedge clock);
      check_eq({tag, "_strobes"}, 32'({spi_miso, tx_ready, rx_valid, tx_underflow,
                                       frame_active, frame_done, frame_abort}), 32'd0);
      check_eq({tag, "_rx_data"}, 32'(rx_data), 32'd0);
      check_eq({tag, "_fbytes"},  32'(frame_bytes), 32'd0);
      wait_cyc(1);
   endtask

   initial begin
      int d0, p0, u0;
      reset = 1'b1; spi_csb = 1'b0; spi_clock = 1'b0; spi_mosi = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00;
      wait_cyc(3);
      check_reset_outs("rst0");
      reset = 1'b0;

      // Reset with csb low: SCK activity must be ignored until csb cycles
      d0 = n_done; p0 = n_pop; u0 = n_unf;
      sck_bits(8, 4);
      wait_cyc(10);
      check_eq("t1_pops",   32'(n_pop - p0), 32'd0);
      check_eq("t1_unf",    32'(n_unf - u0), 32'd0);
      check_eq("t1_done",   32'(n_done - d0), 32'd0);
      check_eq("t1_active", 32'(frame_active), 32'd0);
      spi_csb = 1'b1;
      wait_cyc(10);
      tx_q.push_back(8'h96); push_bits(8'h96, 8); exp_rx.push_back(8'h69);
      d0 = n_done; p0 = n_pop; u0 = n_unf;
      frame(8, 32'h69, 8, 1'b1);
      expect_frame("t1", d0, p0, u0, 1, 0, 1, 0);

      // Two-byte frame with a two-entry tx stream
      tx_q.push_back(8'hA5); tx_q.push_back(8'h3C);
      push_bits(8'hA5, 8); push_bits(8'h3C, 8);
      exp_rx.push_back(8'h5A); exp_rx.push_back(8'hC3);
      wait_cyc(2);
      d0 = n_done; p0 = n_pop; u0 = n_unf;
      frame(16, 32'h5AC3, 8, 1'b1);
      expect_frame("t2", d0, p0, u0, 2, 0, 2, 0);

      // No tx data: IDLE_BYTE goes out and underflow strobes once
      push_bits(8'h00, 8); exp_rx.push_back(8'hFF);
      d0 = n_done; p0 = n_pop; u0 = n_unf;
      frame(8, 32'hFF, 8, 1'b1);
      expect_frame("t3", d0, p0, u0, 1, 0, 0, 1);
      check_eq("t3_rx_data", 32'(rx_data), 32'hFF);

      // 11-bit frame: one byte plus an aborted partial byte
      tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
      push_bits(8'h11, 8); push_bits(8'h22, 3); exp_rx.push_back(8'hB3);
      wait_cyc(2);
      d0 = n_done; p0 = n_pop; u0 = n_unf;
      frame(11, 32'h59D, 8, 1'b1);
      expect_frame("t4", d0, p0, u0, 1, 1, 2, 0);
      tx_q.delete();
      wait_cyc(2);

      // Minimum SCK timing: four clock cycles per SCK period
      exp_rx.push_back(8'hDE); exp_rx.push_back(8'hAD);
      exp_rx.push_back(8'hBE); exp_rx.push_back(8'hEF);
      d0 = n_done; p0 = n_pop; u0 = n_unf;
      frame(32, 32'hDEADBEEF, 2, 1'b0);
      expect_frame("t5", d0, p0, u0, 4, 0, 0, 4);

      // Reset mid-byte with csb held low, master carries on
      tx_q.push_back(8'h77);
      wait_cyc(2);
      d0 = n_done; p0 = n_pop; u0 = n_unf;
      spi_csb = 1'b0;
      wait_cyc(8);
      sck_bits(4, 4);
      reset = 1'b1;
      wait_cyc(2);
      check_reset_outs("rst6");
      reset = 1'b0;
      sck_bits(12, 4);
      spi_csb = 1'b1;
      wait_cyc(10);
      check_eq("t6_done", 32'(n_done - d0), 32'd0);
      check_eq("t6_pops", 32'(n_pop - p0), 32'd1);
      check_eq("t6_unf",  32'(n_unf - u0), 32'd0);
      tx_q.delete();
      tx_q.push_back(8'hC5); push_bits(8'hC5, 8); exp_rx.push_back(8'h3A);
      wait_cyc(2);
      d0 = n_done; p0 = n_pop; u0 = n_unf;
      frame(8, 32'h3A, 4, 1'b1);
      expect_frame("t6", d0, p0, u0, 1, 0, 1, 0);

      check_eq("rx_leftover",   32'(exp_rx.size()),   32'd0);
      check_eq("miso_leftover", 32'(exp_miso.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
